proj_fm_bitmap_scanner: RTL and testbench

Flajolet-Martin sketch core for the MinHash/FM datapath.
- Accepts hash words tagged with a sketch index. The index comes from the upstream FM index counter, which cycles 0..FM_BUFFER_SIZE-1.
- ORs the rho bit of each hash into a per-sketch bitmap.
- On the counter's finish pulse, scans all bitmaps one per cycle and sums the per-sketch R values.
- The summed R is passed to the downstream averaging/estimate logic.

---
 rtl/proj_fm_bitmap_scanner.sv | 119 +++++++++++
 tb/tb_proj_fm_bitmap_scanner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_fm_bitmap_scanner.sv
// Flajolet-Martin sketch core: ORs the rho bit of each hash into a per-sketch bitmap,
// then, on finish, scans every bitmap (one per cycle) and sums the per-sketch R values.
// Latency: finish sampled at edge t -> out_done in cycle t+FM_BUFFER_SIZE+1; no hash accepted while busy.
module proj_fm_bitmap_scanner #(
  parameter int FM_BUFFER_SIZE = 8,
  parameter int HASH_W         = 32,
  parameter int IDX_W          = $clog2(FM_BUFFER_SIZE),
  parameter int SUM_W          = $clog2(FM_BUFFER_SIZE*HASH_W+1)
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_hash_valid,
  input  logic [HASH_W-1:0] in_hash,
  input  logic [IDX_W-1:0]  in_sketch_idx,
  output logic              out_hash_ready,
  input  logic              in_finish,
  output logic              out_busy,
  output logic [SUM_W-1:0]  out_r_sum,
  output logic              out_done
);

  localparam int RHO_W = $clog2(HASH_W);
  localparam int R_W   = $clog2(HASH_W+1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t            state_q;
  logic [HASH_W-1:0] bitmap_q [FM_BUFFER_SIZE];
  logic [IDX_W-1:0]  ptr_q;
  logic [SUM_W-1:0]  acc_q;
  logic [SUM_W-1:0]  r_sum_q;
  logic              done_q;
  logic              busy_q;

  logic [RHO_W-1:0]  rho_d;
  logic [HASH_W-1:0] cur_bitmap;
  logic [R_W-1:0]    r_d;
  logic [SUM_W-1:0]  acc_d;
  logic [IDX_W-1:0]  ptr_d;
  logic              xfer;

  assign out_hash_ready = (state_q == ST_IDLE) && !in_rst;
  assign xfer           = in_hash_valid && out_hash_ready;
  assign out_busy       = busy_q;
  assign out_r_sum      = r_sum_q;
  assign out_done       = done_q;

  // rho: index of the lowest set bit; an all-zero hash saturates to the top bit
  always_comb begin
    rho_d = RHO_W'(HASH_W-1);
    for (int i = HASH_W-1; i >= 0; i--) begin
      if (in_hash[i]) rho_d = RHO_W'(i);
    end
  end

  // R of the bitmap under the scan pointer: lowest clear bit, or HASH_W when full
  always_comb begin
    cur_bitmap = bitmap_q[ptr_q];
    r_d        = R_W'(HASH_W);
    for (int i = HASH_W-1; i >= 0; i--) begin
      if (!cur_bitmap[i]) r_d = R_W'(i);
    end
    acc_d = acc_q + SUM_W'(r_d);
    ptr_d = ptr_q + IDX_W'(1);
  end

  // Control FSM plus bitmap storage; reset discards any scan in progress
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      acc_q   <= '0;
      r_sum_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int s = 0; s < FM_BUFFER_SIZE; s++) bitmap_q[s] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // a transfer coinciding with finish lands before the scan reads it
          if (xfer) begin
            bitmap_q[in_sketch_idx] <= bitmap_q[in_sketch_idx] | (HASH_W'(1) << rho_d);
          end
          if (in_finish) begin
            state_q <= ST_SCAN;
            acc_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SCAN: begin
          acc_q <= acc_d;
          ptr_q <= ptr_d;
          if (ptr_q == IDX_W'(FM_BUFFER_SIZE-1)) begin
            state_q <= ST_DONE;
            r_sum_q <= acc_d;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          for (int s = 0; s < FM_BUFFER_SIZE; s++) bitmap_q[s] <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proj_fm_bitmap_scanner.sv
// Bench for proj_fm_bitmap_scanner: directed scenarios plus randomized batches
// checked against a sketch model built from trailing-zero / lowest-zero rules.
`timescale 1ns/1ps
module tb_proj_fm_bitmap_scanner;

  localparam int N      = 8;
  localparam int HASH_W = 32;
  localparam int IDX_W  = $clog2(N);
  localparam int SUM_W  = $clog2(N*HASH_W+1);

  logic              in_clk = 1'b0;
  logic              in_rst;
  logic              in_hash_valid;
  logic [HASH_W-1:0] in_hash;
  logic [IDX_W-1:0]  in_sketch_idx;
  logic              out_hash_ready;
  logic              in_finish;
  logic              out_busy;
  logic [SUM_W-1:0]  out_r_sum;
  logic              out_done;

  int errors = 0;
  int checks = 0;

  // reference sketches
  logic [HASH_W-1:0] model_bm [N];

  proj_fm_bitmap_scanner #(.FM_BUFFER_SIZE(N), .HASH_W(HASH_W)) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_hash_valid (in_hash_valid),
    .in_hash       (in_hash),
    .in_sketch_idx (in_sketch_idx),
    .out_hash_ready(out_hash_ready),
    .in_finish     (in_finish),
    .out_busy      (out_busy),
    .out_r_sum     (out_r_sum),
    .out_done      (out_done)
  );

  always #5 in_clk = ~in_clk;

  function automatic int trailing_zeros(input logic [HASH_W-1:0] h);
    int n = 0;
    if (h == 0) return HASH_W-1;
    while (h[n] == 1'b0) n++;
    return n;
  endfunction

  function automatic int lowest_zero(input logic [HASH_W-1:0] b);
    int n = 0;
    while (n < HASH_W && b[n] == 1'b1) n++;
    return n;
  endfunction

  function automatic int model_sum();
    int s = 0;
    for (int k = 0; k < N; k++) s += lowest_zero(model_bm[k]);
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) model_bm[k] = '0;
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // offer one hash in IDLE; it must be accepted
  task automatic send(input int idx, input logic [HASH_W-1:0] h);
    in_hash_valid = 1'b1;
    in_hash       = h;
    in_sketch_idx = IDX_W'(idx);
    checks++;
    if (out_hash_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: ready=%b required 1 (idx=%0d hash=%h)", out_hash_ready, idx, h);
    end
    model_bm[idx] = model_bm[idx] | (HASH_W'(1) << trailing_zeros(h));
    tick();
    in_hash_valid = 1'b0;
  endtask

  // pulse finish (optionally with a hash in the same cycle), then check the
  // whole busy window, done timing and the sum; junk=1 hammers inputs meanwhile
  task automatic run_scan(input int exp_sum, input bit junk, input string tag);
    int k;
    in_finish = 1'b1;
    tick();
    in_finish = 1'b0;
    in_hash_valid = 1'b0;
    model_clear();
    for (k = 1; k <= N; k++) begin
      if (junk) begin
        in_hash_valid = 1'b1;
        in_hash       = $urandom;
        in_sketch_idx = IDX_W'($urandom_range(0, N-1));
        in_finish     = ($urandom_range(0, 1) == 1);
      end
      checks++;
      if (out_busy !== 1'b1 || out_done !== 1'b0 || out_hash_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_scan_cyc%0d: busy=%b done=%b ready=%b required 1 0 0",
                 tag, k, out_busy, out_done, out_hash_ready);
      end
      tick();
    end
    if (junk) begin
      in_hash_valid = 1'b1;
      in_finish     = 1'b1;
    end
    checks++;
    if (out_done !== 1'b1 || out_busy !== 1'b1 || out_hash_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_cycle: done=%b busy=%b ready=%b required 1 1 0",
               tag, out_done, out_busy, out_hash_ready);
    end
    checks++;
    if (out_r_sum !== SUM_W'(exp_sum)) begin
      errors++;
      $display("FAIL %s_sum: r_sum=%0d required %0d", tag, out_r_sum, exp_sum);
    end
    tick();
    in_hash_valid = 1'b0;
    in_finish     = 1'b0;
    checks++;
    if (out_done !== 1'b0 || out_busy !== 1'b0 || out_hash_ready !== 1'b1 ||
        out_r_sum !== SUM_W'(exp_sum)) begin
      errors++;
      $display("FAIL %s_after_done: done=%b busy=%b ready=%b r_sum=%0d required 0 0 1 %0d",
               tag, out_done, out_busy, out_hash_ready, out_r_sum, exp_sum);
    end
    if (junk) begin
      // the finish pulses offered during SCAN/DONE must not start another scan
      tick();
      checks++;
      if (out_busy !== 1'b0 || out_done !== 1'b0) begin
        errors++;
        $display("FAIL %s_no_rescan: busy=%b done=%b required 0 0", tag, out_busy, out_done);
      end
    end
  endtask

  task automatic test_reset();
    in_rst = 1'b1;
    in_hash_valid = 1'b0;
    in_hash = '0;
    in_sketch_idx = '0;
    in_finish = 1'b0;
    model_clear();
    tick();
    tick();
    checks++;
    if (out_hash_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_in_reset: ready=%b required 0", out_hash_ready);
    end
    in_rst = 1'b0;
    #1;
    checks++;
    if (out_r_sum !== '0 || out_done !== 1'b0 || out_busy !== 1'b0 || out_hash_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: r_sum=%0d done=%b busy=%b ready=%b required 0 0 0 1",
               out_r_sum, out_done, out_busy, out_hash_ready);
    end
    run_scan(0, 1'b0, "reset_empty");
  endtask

  task automatic test_basic();
    send(2, 32'h1);
    send(2, 32'h2);
    send(2, 32'h4);
    send(2, 32'h4);
    run_scan(3, 1'b0, "basic");
  endtask

  task automatic test_boundary();
    for (int k = 0; k < HASH_W; k++) send(0, HASH_W'(1) << k);
    send(7, 32'h0);
    run_scan(32, 1'b0, "boundary_a");
    send(5, 32'h0);
    for (int k = 0; k < HASH_W-1; k++) send(5, HASH_W'(1) << k);
    run_scan(32, 1'b0, "boundary_b");
  endtask

  task automatic test_simultaneous();
    // hash to sketch 1 in the very cycle finish is sampled
    in_hash_valid = 1'b1;
    in_hash       = 32'h1;
    in_sketch_idx = IDX_W'(1);
    model_bm[1]   = 32'h1;
    checks++;
    if (out_hash_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_ready: ready=%b required 1", out_hash_ready);
    end
    run_scan(1, 1'b1, "simul");
    run_scan(0, 1'b0, "simul_nothing_leaked");
  endtask

  task automatic test_clear_after_done();
    send(2, 32'h1);
    send(2, 32'h2);
    send(2, 32'h4);
    run_scan(3, 1'b0, "clear_first");
    run_scan(0, 1'b0, "clear_second");
  endtask

  task automatic test_reset_mid_scan();
    send(2, 32'h1);
    send(2, 32'h2);
    send(2, 32'h4);
    in_finish = 1'b1;
    tick();
    in_finish = 1'b0;
    for (int k = 1; k < 4; k++) tick();
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (out_done !== 1'b0 || out_busy !== 1'b0 || out_r_sum !== '0 || out_hash_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: done=%b busy=%b r_sum=%0d ready=%b required 0 0 0 1",
               out_done, out_busy, out_r_sum, out_hash_ready);
    end
    for (int k = 0; k < N+2; k++) begin
      tick();
      checks++;
      if (out_done !== 1'b0 || out_busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet_cyc%0d: done=%b busy=%b required 0 0", k, out_done, out_busy);
      end
    end
    run_scan(0, 1'b0, "midrst_next");
  endtask

  task automatic test_random();
    for (int b = 0; b < 12; b++) begin
      int cnt = $urandom_range(0, 40);
      for (int j = 0; j < cnt; j++) begin
        logic [HASH_W-1:0] h;
        case ($urandom_range(0, 3))
          0:       h = '0;
          1:       h = HASH_W'(1) << $urandom_range(0, HASH_W-1);
          default: h = $urandom << $urandom_range(0, 7);
        endcase
        if ($urandom_range(0, 3) == 0) tick();
        send($urandom_range(0, N-1), h);
      end
      run_scan(model_sum(), (b % 3) == 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_simultaneous();
    test_reset_mid_scan();
    test_clear_after_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
